// File: rtl/ctw_sat_pkg.sv
// Shared constants for the IoT-satellite frame generator: mode encodings,
// sync words, LFSR seeds and taps, CRC polynomial and frame length.
package ctw_sat_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_UL   = 2'b01,
        MODE_DL   = 2'b10,
        MODE_ALT  = 2'b11
    } mode_e;

    localparam logic [7:0]  SYNC_UL   = 8'hA5;
    localparam logic [7:0]  SYNC_DL   = 8'h5A;
    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [7:0]  CRC_POLY  = 8'h07;
    localparam int          FRAME_LEN = 32;

    // Seed table indexed by seed_sel.
    function automatic logic [15:0] seed_of(input logic [1:0] sel);
        logic [15:0] s;
        case (sel)
            2'd0:    s = 16'hACE1;
            2'd1:    s = 16'h1234;
            2'd2:    s = 16'hBEEF;
            default: s = 16'hC0DE;
        endcase
        return s;
    endfunction

    // CRC-8, init 0, MSB-first, no reflection, no final XOR.
    function automatic logic [7:0] crc8(input logic [23:0] data);
        logic [7:0] crc;
        logic       fb;
        crc = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            fb  = crc[7] ^ data[i];
            crc = {crc[6:0], 1'b0};
            if (fb) begin
                crc = crc ^ CRC_POLY;
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/ctw_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load. While a load is pending the output
// follows the live seed, so the value used at the next step is always the
// seed selected at that moment; a step clears the pending load.
module ctw_lfsr16
    import ctw_sat_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ena_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [15:0] seed_i,
    output logic [15:0] value_o
);

    logic [15:0] q_q, q_d;
    logic        ld_q, ld_d;

    assign value_o = ld_q ? seed_i : q_q;

    // Next state: request a seed load, or shift in the feedback bit.
    always_comb begin
        q_d  = q_q;
        ld_d = ld_q;
        if (ena_i) begin
            if (load_i) begin
                ld_d = 1'b1;
            end else if (step_i) begin
                q_d  = {value_o[14:0], ^(value_o & LFSR_TAPS)};
                ld_d = 1'b0;
            end
        end
    end

    // State register; reset leaves a seed load pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q  <= 16'h0000;
            ld_q <= 1'b1;
        end else begin
            q_q  <= q_d;
            ld_q <= ld_d;
        end
    end

endmodule

// File: rtl/ctw_iot_satellite.sv
// IoT-satellite link frame generator top: periodic 32-bit UL/DL frames
// (sync, LFSR payload, check byte) shifted out MSB-first, one bit per clock.
// Build option: define CTW_CRC8_EN for a CRC-8 check byte instead of XOR.
module ctw_iot_satellite
    import ctw_sat_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    function automatic logic [7:0] check_byte(input logic [7:0] s, input logic [15:0] p);
`ifdef CTW_CRC8_EN
        return crc8({s, p});
`else
        return s ^ p[15:8] ^ p[7:0];
`endif
    endfunction

    mode_e       mode;
    logic [3:0]  per_in;
    logic [15:0] seed;
    logic [15:0] lfsr_val;

    logic [8:0]  timer_q, timer_d;
    logic [3:0]  per_q, per_d;
    logic        active_q, active_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic [7:0]  chk_cur_q, chk_cur_d;
    logic        alt_q, alt_d;
    logic        tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        dir_q, dir_d;
    logic        fs_q, fs_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  chk_out_q, chk_out_d;

    logic        busy, start, frame_end, new_dir;
    logic [7:0]  sync_w, chk_new;
    logic [31:0] frame_w;
    logic [4:0]  per_p2;
    logic [8:0]  interval_m1;
    logic        unused_uio;

    assign mode   = mode_e'(ui_in[1:0]);
    assign per_in = ui_in[5:2];
    assign seed   = seed_of(ui_in[7:6]);
    assign unused_uio = ^uio_in;

    // Interval length uses the period captured at the last frame start.
    assign per_p2      = {1'b0, per_q} + 5'd2;
    assign interval_m1 = {per_p2, 4'b0000} - 9'd1;

    // A frame already shifting (bits still to go) can never be restarted.
    assign busy      = active_q && (bit_cnt_q != 5'd0);
    assign start     = ena && (mode != MODE_IDLE) && (timer_q == 9'd0) && !busy;
    assign frame_end = ena && active_q && (bit_cnt_q == 5'd0);

    assign new_dir = (mode == MODE_DL) || ((mode == MODE_ALT) && alt_q);
    assign sync_w  = new_dir ? SYNC_DL : SYNC_UL;
    assign chk_new = check_byte(sync_w, lfsr_val);
    assign frame_w = {sync_w, lfsr_val, chk_new};

    ctw_lfsr16 u_lfsr (
        .clk_i   (clk),
        .rst_i   (rst),
        .ena_i   (ena),
        .load_i  ((mode == MODE_IDLE) && !active_q),
        .step_i  (start),
        .seed_i  (seed),
        .value_o (lfsr_val)
    );

    // Next state for timer, shifter, direction toggle and output registers.
    always_comb begin
        timer_d    = timer_q;
        per_d      = per_q;
        active_d   = active_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        chk_cur_d  = chk_cur_q;
        alt_d      = alt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        dir_d      = dir_q;
        fs_d       = fs_q;
        cnt_d      = cnt_q;
        chk_out_d  = chk_out_q;
        if (ena) begin
            if (mode == MODE_IDLE) begin
                timer_d = 9'd0;
            end else if (start) begin
                timer_d = 9'd1;
            end else if (timer_q != 9'd0) begin
                timer_d = (timer_q == interval_m1) ? 9'd0 : timer_q + 9'd1;
            end

            if (mode != MODE_ALT) begin
                alt_d = 1'b0;
            end else if (start) begin
                alt_d = ~alt_q;
            end

            fs_d = start;
            if (start) begin
                per_d      = per_in;
                active_d   = 1'b1;
                bit_cnt_d  = 5'(FRAME_LEN - 1);
                shreg_d    = {frame_w[30:0], 1'b0};
                tx_data_d  = frame_w[31];
                tx_valid_d = 1'b1;
                dir_d      = new_dir;
                chk_cur_d  = chk_new;
            end else if (frame_end) begin
                active_d   = 1'b0;
                tx_data_d  = 1'b0;
                tx_valid_d = 1'b0;
            end else if (active_q) begin
                tx_data_d  = shreg_q[31];
                shreg_d    = {shreg_q[30:0], 1'b0};
                bit_cnt_d  = bit_cnt_q - 5'd1;
            end

            if (frame_end) begin
                cnt_d     = cnt_q + 4'd1;
                chk_out_d = chk_cur_q;
            end
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q    <= 9'd0;
            per_q      <= 4'd0;
            active_q   <= 1'b0;
            bit_cnt_q  <= 5'd0;
            shreg_q    <= 32'd0;
            chk_cur_q  <= 8'd0;
            alt_q      <= 1'b0;
            tx_data_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            dir_q      <= 1'b0;
            fs_q       <= 1'b0;
            cnt_q      <= 4'd0;
            chk_out_q  <= 8'd0;
        end else begin
            timer_q    <= timer_d;
            per_q      <= per_d;
            active_q   <= active_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            chk_cur_q  <= chk_cur_d;
            alt_q      <= alt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            dir_q      <= dir_d;
            fs_q       <= fs_d;
            cnt_q      <= cnt_d;
            chk_out_q  <= chk_out_d;
        end
    end

    assign uo_out  = {cnt_q, fs_q, dir_q, tx_valid_q, tx_data_q};
    assign uio_out = chk_out_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_ctw_iot_satellite.sv
// Directed bench for ctw_iot_satellite (default XOR check byte build).
module tb_ctw_iot_satellite;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;

    ctw_iot_satellite dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int max, output bit found, output int t);
        found = 1'b0;
        t     = 0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (uo_out[3] === 1'b1) begin
                found = 1'b1;
                t     = cyc;
                break;
            end
        end
    endtask

    // Called on the negedge showing bit 31; returns on the one showing bit 0.
    task automatic read_frame(input int chg_at, input logic [7:0] chg_val, input int hold_at,
                              output logic [31:0] f, output bit vld_ok, output bit frz_ok);
        logic [1:0] snap;
        f      = '0;
        f[31]  = uo_out[0];
        vld_ok = (uo_out[1] === 1'b1);
        frz_ok = 1'b1;
        for (int i = 30; i >= 0; i--) begin
            if (i + 1 == chg_at) ui_in = chg_val;
            if (i + 1 == hold_at) begin
                snap = uo_out[1:0];
                ena  = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    if (uo_out[1:0] !== snap) frz_ok = 1'b0;
                end
                ena = 1'b1;
            end
            @(negedge clk);
            f[i] = uo_out[0];
            if (uo_out[1] !== 1'b1) vld_ok = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] f;
        logic [31:0] exp3 [4];
        bit          found, v, z;
        int          t0, t1;

        exp3[0] = 32'hA5ACE1E8;
        exp3[1] = 32'h5A59C3C0;
        exp3[2] = 32'hA5B38791;
        exp3[3] = 32'h5A670F32;
        t0 = 0;
        t1 = 0;

        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h3C;
        repeat (3) @(negedge clk);
        chk("rst_uo_out", 32'(uo_out), 32'h00);
        chk("rst_uio_out", 32'(uio_out), 32'h00);
        chk("rst_uio_oe", 32'(uio_oe), 32'hFF);

        // UL only, P=1, seed 0xACE1
        ui_in = 8'h05;
        rst   = 1'b0;
        wait_start(4, found, t0);
        chk("ul_found", 32'(found), 32'd1);
        chk("ul_dir", 32'(uo_out[2]), 32'd0);
        read_frame(-1, 8'h00, -1, f, v, z);
        chk("ul_frame1", f, 32'hA5ACE1E8);
        chk("ul_valid", 32'(v), 32'd1);
        @(negedge clk);
        chk("ul_end_txbits", 32'(uo_out[1:0]), 32'd0);
        chk("ul_uio_out", 32'(uio_out), 32'hE8);
        chk("ul_cnt", 32'(uo_out[7:4]), 32'd1);
        wait_start(60, found, t1);
        chk("ul_found2", 32'(found), 32'd1);
        chk("ul_gap", 32'(t1 - t0), 32'd48);
        read_frame(-1, 8'h00, -1, f, v, z);
        chk("ul_frame2", f, 32'hA559C33F);

        // DL only
        ui_in = 8'h06;
        wait_start(60, found, t0);
        chk("dl_gap", 32'(t0 - t1), 32'd48);
        chk("dl_dir", 32'(uo_out[2]), 32'd1);
        read_frame(-1, 8'h00, -1, f, v, z);
        chk("dl_frame", f, 32'h5AB3876E);
        @(negedge clk);
        chk("dl_uio_out", 32'(uio_out), 32'h6E);
        chk("dl_cnt", 32'(uo_out[7:4]), 32'd3);
        chk("dl_end_dir", 32'(uo_out[2]), 32'd1);

        // reset in the middle of a frame
        wait_start(60, found, t1);
        chk("abort_found", 32'(found), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_uo_out", 32'(uo_out), 32'h00);
        chk("abort_uio_out", 32'(uio_out), 32'h00);

        // alternate, P=3
        ui_in = 8'h0F;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            wait_start(100, found, t1);
            chk("alt_found", 32'(found), 32'd1);
            if (n > 0) chk("alt_gap", 32'(t1 - t0), 32'd80);
            t0 = t1;
            chk("alt_dir", 32'(uo_out[2]), 32'(n % 2));
            read_frame(-1, 8'h00, -1, f, v, z);
            chk("alt_frame", f, exp3[n]);
            @(negedge clk);
            chk("alt_cnt", 32'(uo_out[7:4]), 32'(n + 1));
            chk("alt_end_valid", 32'(uo_out[1]), 32'd0);
        end

        // mode 00 asserted mid-frame: frame completes, nothing follows
        wait_start(100, found, t1);
        chk("idle_gap", 32'(t1 - t0), 32'd80);
        read_frame(20, 8'h0C, -1, f, v, z);
        chk("idle_frame", f, 32'hA5CE1E75);
        chk("idle_valid", 32'(v), 32'd1);
        @(negedge clk);
        chk("idle_cnt", 32'(uo_out[7:4]), 32'd5);
        chk("idle_uio_out", 32'(uio_out), 32'h75);
        wait_start(200, found, t1);
        chk("idle_nostart", 32'(found), 32'd0);
        chk("idle_txvalid", 32'(uo_out[1]), 32'd0);

        // ena low for 10 cycles mid-frame
        ui_in = 8'h05;
        wait_start(4, found, t0);
        chk("ena_found", 32'(found), 32'd1);
        read_frame(-1, 8'h00, 20, f, v, z);
        chk("ena_frame", f, 32'hA5ACE1E8);
        chk("ena_frozen", 32'(z), 32'd1);
        chk("ena_valid", 32'(v), 32'd1);
        @(negedge clk);
        chk("ena_cnt", 32'(uo_out[7:4]), 32'd6);
        wait_start(80, found, t1);
        chk("ena_found2", 32'(found), 32'd1);
        chk("ena_gap", 32'(t1 - t0), 32'd58);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
